// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, widths, reset PC and offset helper.
package instruction_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StHalted = 1'b1
    } fetch_state_e;

    // Word offset to byte offset: sign-extend then shift left by two.
    function automatic logic [31:0] sext_shift2(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, IF/ID handshake, redirect requests and status.
interface instruction_fetch_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             id_ready;
    logic             branch_en;
    logic [15:0]      branch_imm16;
    logic             jump_en;
    logic [25:0]      jump_addr26;
    logic             jr_en;
    logic [31:0]      jr_target;
    logic             halt_req;
    logic             halted;
    logic             align_fault;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, align_fault, fetch_count,
        input  imem_data, id_ready, branch_en, branch_imm16, jump_en, jump_addr26, jr_en,
               jr_target, halt_req
    );

    modport slave (
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, align_fault, fetch_count,
        output imem_data, id_ready, branch_en, branch_imm16, jump_en, jump_addr26, jr_en,
               jr_target, halt_req
    );
endinterface

// File: rtl/instruction_fetch_next_pc.sv
// Redirect target selection (jr > jump > branch) relative to the held IF/ID word, plus
// alignment check of the chosen target.
module instruction_fetch_next_pc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic        branch_en,
    input  logic [15:0] branch_imm16,
    input  logic        jump_en,
    input  logic [25:0] jump_addr26,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] target,
    output logic        redirect_req,
    output logic        misaligned
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign branch_target = pc4 + sext_shift2(branch_imm16);
    assign jump_target   = {pc4[31:28], jump_addr26, 2'b00};

    always_comb begin
        target = branch_target;
        if (jr_en) begin
            target = jr_target;
        end else if (jump_en) begin
            target = jump_target;
        end
    end

    assign redirect_req = jr_en | jump_en | branch_en;
    assign misaligned   = redirect_req & (target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory and holds one fetched word in IF/ID
// behind a valid/ready handshake; redirects and halt are resolved against the held word.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 32
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] target;
    logic        redirect_req;
    logic        misaligned;
    logic        consume;
    logic        redirect;
    logic [31:0] pc_plus4;

    instruction_fetch_next_pc u_next_pc (
        .pc4          (pc4_q),
        .branch_en    (bus.branch_en),
        .branch_imm16 (bus.branch_imm16),
        .jump_en      (bus.jump_en),
        .jump_addr26  (bus.jump_addr26),
        .jr_en        (bus.jr_en),
        .jr_target    (bus.jr_target),
        .target       (target),
        .redirect_req (redirect_req),
        .misaligned   (misaligned)
    );

    assign consume  = valid_q & bus.id_ready;
    assign redirect = consume & redirect_req;
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (redirect ? misaligned : bus.halt_req) begin
                    state_d = StHalted;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        bus.halted = (state_q == StHalted);
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        if (state_q == StRun) begin
            if (redirect) begin
                // The held word is wrong-path: squash it and do not capture this cycle.
                valid_d = 1'b0;
                if (misaligned) begin
                    fault_d = 1'b1;
                end else begin
                    pc_d = target;
                end
            end else if (bus.halt_req) begin
                if (consume) begin
                    valid_d = 1'b0;
                end
            end else if (!valid_q || consume) begin
                instr_d = bus.imem_data;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
                count_d = count_q + CNT_W'(1);
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.align_fault = fault_q;
    assign bus.fetch_count = count_q;

endmodule
